timer_arbiter: RTL
==================

# timer_arbiter

Shares a single interval timer among up to NUM_REQ game sub-blocks (pattern display sequencer, player-input timeout, LED blink, and similar). Each requester asks for a delay of N units, where one unit is PRESCALE base-tick enables. The arbiter grants the timer round-robin, counts the delay, and returns a one-cycle done pulse to the winner. It sits between the game FSMs and the base-tick enable source.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- CNT_W, 8: width of each requested duration in units.
- PRESCALE, 100: base-tick enables per unit, ≥1.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  base-tick strobe; counts only when high.
- req  in  NUM_REQ  per-requester request level, held until done.
- dur  in  NUM_REQ*CNT_W  flattened durations, requester i at bits [i*CNT_W +: CNT_W].
- grant  out  NUM_REQ  one-hot owner of the timer, zero when idle.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- busy  out  1  high in LOAD and RUN.

## Operation
- States: IDLE, LOAD, RUN, FINISH.
- IDLE, no req: stay.
- IDLE, any req: pick the first set bit searching from the pointer upward, wrapping at NUM_REQ. Latch its index and dur, clear the unit and prescale counters, then go to LOAD.
- LOAD: grant asserted.
  - Latched dur == 0: go to FINISH (zero-length delay).
  - Otherwise go to RUN.
  - enable is ignored in LOAD.
- RUN: each enable increments the prescale counter.
  - At PRESCALE-1 with enable: prescale counter wraps to 0 and the unit counter increments.
  - When the unit counter reaches latched dur-1 at a prescale wrap: go to FINISH.
- FINISH: grant = 0, done[idx] = 1 for exactly one cycle, pointer = idx+1 modulo NUM_REQ, then go to IDLE.
- dur changes after latching are ignored. req of non-granted requesters is ignored until IDLE.
- A requester still asserting req in the IDLE cycle after its done is eligible again, but it gets lowest priority.
- Unit counter is CNT_W bits, prescale counter is clog2(PRESCALE) bits (minimum 1). Neither can overflow, because the terminal compare fires first.
- Reset values: grant=0, done=0, busy=0, pointer=0, state IDLE, counters 0.
- rst during any state, including RUN or FINISH, aborts immediately with no done pulse.

## Timing
- req first seen high in IDLE at cycle t: grant and busy high from t+1.
- RUN starts at t+2 when dur≠0.
- With enable tied high, done fires at t+2+dur*PRESCALE.
- dur=0: done at t+2.
- Minimum spacing between consecutive grants is 3 cycles (grant, FINISH, IDLE, next grant).
- FINISH→IDLE: the new arbitration decision uses the pointer already updated in FINISH.

## Configuration
- TIMER_ARBITER_ABORT_EN defined:
  - If req[idx] is low in LOAD or RUN, go directly to IDLE with no done pulse.
  - grant drops the next cycle.
  - The pointer still advances to idx+1.
- Not defined: req is not monitored after grant. The delay runs to completion and done pulses even if the requester has withdrawn.

## Structure
- Package timer_arbiter_pkg holds:
  - state encoding constants ST_IDLE, ST_LOAD, ST_RUN, ST_FINISH (2 bits)
  - a constant function for clog2.
- Sub-module tick_prescaler has these ports:
  - inputs: clk, rst, clr, enable
  - output: unit_tick, which is high on the enable that completes PRESCALE counts
  - parameter: PRESCALE.
- The top module holds the FSM, round-robin pointer, dur mux/latch, and unit counter.

## Test plan
- Reset, then req=4'b0010 with dur[1]=3, enable=1, PRESCALE=100: grant=0010 one cycle after req, done=0010 exactly 302 cycles after req seen, busy low after.
- req=4'b1111 held throughout with all dur=1 and PRESCALE=2: grant order is 0001, 0010, 0100, 1000, 0001, with no requester granted twice before the others.
- dur=0 on requester 2: done[2] pulses 2 cycles after req, and the enable count is irrelevant.
- enable pulsed every 4th cycle, dur=2, PRESCALE=3: done only after the 6th enable in RUN, and enables during LOAD are not counted.
- rst asserted mid-RUN: next cycle grant=0, busy=0, no done pulse. After release, requester 0 wins first.
- TIMER_ARBITER_ABORT_EN defined, req dropped mid-RUN: no done pulse, grant=0 next cycle, next arbitration starts from idx+1. Without the macro, done still pulses at the full delay.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin interval timer arbiter.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_arbiter_tick_prescaler.sv
// Divides base-tick enables by PRESCALE; unit_tick marks the enable that closes a unit.
module tick_prescaler
  import timer_arbiter_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enable,
  output logic unit_tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap      = (cnt_q == PW'(PRESCALE - 1));
  assign unit_tick = enable && wrap && !clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared interval timer; delay = dur * PRESCALE enables.
// Optional TIMER_ARBITER_ABORT_EN: a granted requester dropping req cancels its delay.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   dur_q, dur_d;
  logic [CNT_W-1:0]   unit_q, unit_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [CNT_W-1:0]   pick_dur;
  logic [IDX_W-1:0]   idx_next;
  logic               last_unit;
  logic               unit_tick;
  logic               pre_clr;
  logic               pre_en;
  logic               req_lost;

  // First requester at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    pick_dur = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_dur = dur[i*CNT_W +: CNT_W];
      end
    end
  end

  assign idx_next  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  assign last_unit = (unit_q == dur_q - 1'b1);
  assign pre_en    = enable && (state_q == ST_RUN);
  assign pre_clr   = (state_q != ST_RUN);

`ifdef TIMER_ARBITER_ABORT_EN
  assign req_lost = ~req[idx_q];
`else
  assign req_lost = 1'b0;
`endif

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .clr       (pre_clr),
    .enable    (pre_en),
    .unit_tick (unit_tick)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    unit_d  = unit_q;
    grant_d = '0;
    done_d  = '0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_LOAD;
          idx_d             = pick_idx;
          dur_d             = pick_dur;
          unit_d            = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d            = 1'b1;
        end
      end
      ST_LOAD, ST_RUN: begin
        if (req_lost) begin
          state_d = ST_IDLE;
          ptr_d   = idx_next;
        end else if (state_q == ST_LOAD) begin
          if (dur_q == '0) begin
            state_d        = ST_FINISH;
            done_d[idx_q]  = 1'b1;
          end else begin
            state_d = ST_RUN;
            grant_d = grant_q;
            busy_d  = 1'b1;
          end
        end else if (unit_tick && last_unit) begin
          state_d       = ST_FINISH;
          done_d[idx_q] = 1'b1;
        end else begin
          grant_d = grant_q;
          busy_d  = 1'b1;
          if (unit_tick) begin
            unit_d = unit_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        ptr_d   = idx_next;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      unit_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      unit_q  <= unit_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
    dur_q <= dur_d;
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule
